// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit
//   Hardware operand stack for the stack processor datapath. It accepts one
//   push/pop request per cycle, holds up to DEPTH words and returns the popped
//   word on dout one cycle after the pop. It also reports full/empty status and
//   raises sticky overflow/underflow flags.
//
// Ports
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset, beats every request
//   push       in   push din this cycle
//   pop        in   pop the top entry this cycle
//   din        in   word to push
//   clr_err    in   clears the sticky error flags; a new error raised in the
//                   same cycle wins
//   dout       out  last popped word (registered)
//   pop_valid  out  one-cycle pulse when dout was updated by a successful pop
//   tos        out  current top of stack (combinational), 0 when empty
//   count      out  current occupancy, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky: a push was attempted while full
//   underflow  out  sticky: a pop was attempted while empty
// -----------------------------------------------------------------------------
module stack_unit #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Storage and state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]      r_sp;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_pop_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    // Status and decoded requests
    logic                  w_empty;
    logic                  w_full;
    logic [AW-1:0]         w_top_idx;
    logic [AW-1:0]         w_push_idx;
    logic [DATA_WIDTH-1:0] w_top_data;

    logic                  w_do_push;   // push only, room available
    logic                  w_ovf_req;   // push only, stack full
    logic                  w_do_pop;    // pop only, data available
    logic                  w_unf_req;   // pop only, stack empty
    logic                  w_replace;   // push+pop on non-empty stack
    logic                  w_bypass;    // push+pop on empty stack

    logic                  w_mem_we;
    logic [AW-1:0]         w_mem_idx;

    logic [CNT_W-1:0]      w_sp_next;
    logic [DATA_WIDTH-1:0] w_dout_next;
    logic                  w_pop_valid_next;
    logic                  w_overflow_next;
    logic                  w_underflow_next;

    // ------------------------------------------------------------------------
    // Status derived from the stack pointer only
    // ------------------------------------------------------------------------
    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == CNT_W'(DEPTH));
    // When full, sp == DEPTH truncates to 0 which is never used as a push
    // address because pushes are blocked while full.
    assign w_push_idx = AW'(r_sp);
    assign w_top_idx  = AW'(r_sp - CNT_W'(1));
    assign w_top_data = r_mem[w_top_idx];

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    assign w_do_push = push & ~pop & ~w_full;
    assign w_ovf_req = push & ~pop &  w_full;
    assign w_do_pop  = pop & ~push & ~w_empty;
    assign w_unf_req = pop & ~push &  w_empty;
    assign w_replace = push & pop & ~w_empty;
    assign w_bypass  = push & pop &  w_empty;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_sp_next        = r_sp;
        w_dout_next      = r_dout;
        w_pop_valid_next = 1'b0;
        w_mem_we         = 1'b0;
        w_mem_idx        = w_push_idx;

        if (w_do_push) begin
            w_mem_we  = 1'b1;
            w_mem_idx = w_push_idx;
            w_sp_next = r_sp + CNT_W'(1);
        end

        if (w_do_pop) begin
            w_dout_next      = w_top_data;
            w_pop_valid_next = 1'b1;
            w_sp_next        = r_sp - CNT_W'(1);
        end

        // Replace-top: old top leaves on dout, din takes its slot, sp holds.
        if (w_replace) begin
            w_dout_next      = w_top_data;
            w_pop_valid_next = 1'b1;
            w_mem_we         = 1'b1;
            w_mem_idx        = w_top_idx;
        end

        // Bypass: the pushed word is popped straight back out.
        if (w_bypass) begin
            w_dout_next      = din;
            w_pop_valid_next = 1'b1;
        end

        // Set wins over clear.
        w_overflow_next  = w_ovf_req | (r_overflow  & ~clr_err);
        w_underflow_next = w_unf_req | (r_underflow & ~clr_err);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= '0;
            r_dout      <= '0;
            r_pop_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_sp        <= w_sp_next;
            r_dout      <= w_dout_next;
            r_pop_valid <= w_pop_valid_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end
    end

    // Storage is not reset; writes are suppressed while rst is high so a
    // request coinciding with reset leaves no trace.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_idx] <= din;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign dout      = r_dout;
    assign pop_valid = r_pop_valid;
    assign tos       = w_empty ? '0 : w_top_data;
    assign count     = r_sp;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A queue-based reference stack is updated at every rising edge and
//   all DUT outputs are compared against it shortly after that edge.
// -----------------------------------------------------------------------------
module tb_stack_unit;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              push;
    logic              pop;
    logic [DW-1:0]     din;
    logic              clr_err;
    logic [DW-1:0]     dout;
    logic              pop_valid;
    logic [DW-1:0]     tos;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    stack_unit #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       (din),
        .clr_err   (clr_err),
        .dout      (dout),
        .pop_valid (pop_valid),
        .tos       (tos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a plain queue, top at the back.
    // ------------------------------------------------------------------------
    logic [DW-1:0] m_stk[$];
    logic [DW-1:0] m_dout;
    logic          m_pv;
    logic          m_ovf;
    logic          m_unf;
    logic          m_init = 1'b0;

    always @(posedge clk) begin
        logic n_ovf;
        logic n_unf;
        if (rst) begin
            m_stk.delete();
            m_dout = '0;
            m_pv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_init = 1'b1;
        end else begin
            n_ovf = 1'b0;
            n_unf = 1'b0;
            m_pv  = 1'b0;
            if (push && pop) begin
                if (m_stk.size() > 0) begin
                    m_dout = m_stk[m_stk.size() - 1];
                    m_stk[m_stk.size() - 1] = din;
                end else begin
                    m_dout = din;
                end
                m_pv = 1'b1;
            end else if (push) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(din);
                else n_ovf = 1'b1;
            end else if (pop) begin
                if (m_stk.size() > 0) begin
                    m_dout = m_stk.pop_back();
                    m_pv   = 1'b1;
                end else begin
                    n_unf = 1'b1;
                end
            end
            m_ovf = n_ovf | (m_ovf & ~clr_err);
            m_unf = n_unf | (m_unf & ~clr_err);
        end
        #1;
        if (m_init) begin
            chk("count",     32'(count),     32'(m_stk.size()));
            chk("empty",     32'(empty),     32'(m_stk.size() == 0));
            chk("full",      32'(full),      32'(m_stk.size() == DEPTH));
            chk("tos",       32'(tos),
                32'((m_stk.size() == 0) ? 8'h00 : m_stk[m_stk.size() - 1]));
            chk("dout",      32'(dout),      32'(m_dout));
            chk("pop_valid", 32'(pop_valid), 32'(m_pv));
            chk("overflow",  32'(overflow),  32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
        end
    end

    // One request per cycle: drive after the falling edge, return once the
    // rising edge has taken effect.
    task automatic cyc(input logic p, input logic o, input logic [DW-1:0] d,
                       input logic c, input logic r);
        @(negedge clk);
        push    = p;
        pop     = o;
        din     = d;
        clr_err = c;
        rst     = r;
        @(posedge clk);
        #2;
    endtask

    int thresh_push;
    int thresh_pop;

    initial begin
        push = 0; pop = 0; din = '0; clr_err = 0; rst = 0;

        // 1: reset
        cyc(0, 0, 8'h00, 0, 1);
        cyc(0, 0, 8'h00, 0, 1);
        cyc(0, 0, 8'h00, 0, 0);
        chk("t1 count", 32'(count), 0);
        chk("t1 empty", 32'(empty), 1);
        chk("t1 full",  32'(full), 0);
        chk("t1 dout",  32'(dout), 0);

        // 2: LIFO order
        cyc(1, 0, 8'h11, 0, 0);
        cyc(1, 0, 8'h22, 0, 0);
        cyc(1, 0, 8'h33, 0, 0);
        chk("t2 count3", 32'(count), 3);
        cyc(0, 1, 8'h00, 0, 0);
        chk("t2 pop1", 32'(dout), 32'h33);
        chk("t2 pv1",  32'(pop_valid), 1);
        cyc(0, 1, 8'h00, 0, 0);
        chk("t2 pop2", 32'(dout), 32'h22);
        cyc(0, 1, 8'h00, 0, 0);
        chk("t2 pop3", 32'(dout), 32'h11);
        cyc(0, 0, 8'h00, 0, 0);
        chk("t2 pv_low", 32'(pop_valid), 0);
        chk("t2 empty",  32'(empty), 1);

        // 3: fill, overflow, AA never stored
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 0, 0);
        chk("t3 full",  32'(full), 1);
        chk("t3 count", 32'(count), 16);
        cyc(1, 0, 8'hAA, 0, 0);
        chk("t3 count_ovf", 32'(count), 16);
        chk("t3 ovf",       32'(overflow), 1);
        cyc(0, 1, 8'h00, 0, 0);
        chk("t3 pop", 32'(dout), 32'h0F);
        for (int i = 0; i < 15; i++) cyc(0, 1, 8'h00, 0, 0);
        chk("t3 last", 32'(dout), 32'h00);

        // 4: underflow and clear
        cyc(0, 1, 8'h00, 0, 0);
        chk("t4 unf",  32'(underflow), 1);
        chk("t4 pv",   32'(pop_valid), 0);
        chk("t4 dout", 32'(dout), 32'h00);
        cyc(0, 0, 8'h00, 1, 0);
        chk("t4 clr_unf", 32'(underflow), 0);
        chk("t4 clr_ovf", 32'(overflow), 0);
        cyc(0, 1, 8'h00, 1, 0);
        chk("t4 set_wins", 32'(underflow), 1);
        cyc(0, 0, 8'h00, 1, 0);

        // 5: replace-top and bypass
        cyc(1, 0, 8'h05, 0, 0);
        cyc(1, 1, 8'h09, 0, 0);
        chk("t5 dout",  32'(dout), 32'h05);
        chk("t5 pv",    32'(pop_valid), 1);
        chk("t5 count", 32'(count), 1);
        chk("t5 tos",   32'(tos), 32'h09);
        cyc(0, 1, 8'h00, 0, 0);
        chk("t5 pop", 32'(dout), 32'h09);
        cyc(1, 1, 8'h7E, 0, 0);
        chk("t5 byp_dout",  32'(dout), 32'h7E);
        chk("t5 byp_count", 32'(count), 0);
        chk("t5 byp_err",   32'({overflow, underflow}), 0);

        // 6: reset beats push
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'hC0 + i), 0, 0);
        cyc(1, 0, 8'hEE, 0, 1);
        chk("t6 count", 32'(count), 0);
        chk("t6 empty", 32'(empty), 1);
        cyc(0, 1, 8'h00, 0, 0);
        chk("t6 unf", 32'(underflow), 1);

        // Randomized traffic with alternating fill/drain bias
        thresh_push = 70;
        thresh_pop  = 30;
        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) begin
                thresh_push = (thresh_push == 70) ? 30 : 70;
                thresh_pop  = 100 - thresh_push;
            end
            cyc($urandom_range(0, 99) < thresh_push,
                $urandom_range(0, 99) < thresh_pop,
                8'($urandom),
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 299) == 0);
        end
        cyc(0, 0, 8'h00, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
